// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Brief    : Recovers a divide-by-4 pixel strobe and pixel/line position from
//            an incoming hsync/vsync pair, measures line and frame length and
//            flags lock once the timing repeats over consecutive frames.
//            Define VGA_SYNC_DECODER_SYNC_EN to add a two-flop input
//            synchronizer (input-to-event latency +2 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
    parameter int CNT_W       = 11,
    parameter int LOCK_FRAMES = 2,
    parameter int SYNC_POL    = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    output logic             pixTick,
    output logic [CNT_W-1:0] xPos,
    output logic [CNT_W-1:0] yPos,
    output logic [CNT_W-1:0] hTotal,
    output logic [CNT_W-1:0] vTotal,
    output logic             frameStart,
    output logic             locked
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic             c_INV     = (SYNC_POL == 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [4:0]       c_LOCK    = 5'(LOCK_FRAMES);

    logic w_hs_act;
    logic w_vs_act;
    logic w_hs_in;
    logic w_vs_in;

    // Inputs are normalised to active-high before any sampling.
    assign w_hs_act = hsync ^ c_INV;
    assign w_vs_act = vsync ^ c_INV;

`ifdef VGA_SYNC_DECODER_SYNC_EN
    logic [1:0] r_hs_sync;
    logic [1:0] r_vs_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hs_sync <= '0;
            r_vs_sync <= '0;
        end else begin
            r_hs_sync <= {r_hs_sync[0], w_hs_act};
            r_vs_sync <= {r_vs_sync[0], w_vs_act};
        end
    end

    assign w_hs_in = r_hs_sync[1];
    assign w_vs_in = r_vs_sync[1];
`else
    assign w_hs_in = w_hs_act;
    assign w_vs_in = w_vs_act;
`endif

    logic r_hs_q;
    logic r_hs_p;
    logic r_vs_q;
    logic r_vs_p;
    logic w_hs_start;
    logic w_vs_start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hs_q <= 1'b0;
            r_hs_p <= 1'b0;
            r_vs_q <= 1'b0;
            r_vs_p <= 1'b0;
        end else begin
            r_hs_q <= w_hs_in;
            r_hs_p <= r_hs_q;
            r_vs_q <= w_vs_in;
            r_vs_p <= r_vs_q;
        end
    end

    assign w_hs_start = r_hs_q & ~r_hs_p;
    assign w_vs_start = r_vs_q & ~r_vs_p;

    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_xcnt;
    logic [CNT_W-1:0] r_ycnt;
    logic [CNT_W-1:0] r_hmeas;
    logic [CNT_W-1:0] r_vmeas;
    logic             w_pix;
    logic             w_hto;
    logic [CNT_W-1:0] w_xlen;
    logic [CNT_W-1:0] w_hcur;
    logic [CNT_W-1:0] w_vcur;

    assign w_pix = (r_phase == 2'd3);
    assign w_hto = (r_xcnt == c_CNT_MAX);

    // The tick landing on the closing hsStart belongs to the line it ends.
    assign w_xlen = (w_pix && !w_hto) ? (r_xcnt + c_CNT_ONE) : r_xcnt;
    assign w_hcur = w_hs_start ? w_xlen : r_hmeas;
    assign w_vcur = r_ycnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_phase <= 2'd0;
            r_xcnt  <= '0;
            r_ycnt  <= '0;
            r_hmeas <= '0;
            r_vmeas <= '0;
        end else begin
            r_phase <= w_hs_start ? 2'd0 : (r_phase + 2'd1);

            if (w_hs_start) begin
                r_hmeas <= w_xlen;
                r_xcnt  <= '0;
            end else if (w_pix && !w_hto) begin
                r_xcnt <= r_xcnt + c_CNT_ONE;
            end

            if (w_vs_start) begin
                r_vmeas <= r_ycnt;
                r_ycnt  <= '0;
            end else if (w_hs_start) begin
                r_ycnt <= r_ycnt + c_CNT_ONE;
            end
        end
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_match;
    logic [3:0]       w_match_nxt;
    logic [4:0]       w_match_inc;
    logic [CNT_W-1:0] r_htotal;
    logic [CNT_W-1:0] r_vtotal;
    logic [CNT_W-1:0] w_htotal_nxt;
    logic [CNT_W-1:0] w_vtotal_nxt;

    assign w_match_inc = {1'b0, r_match} + 5'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= SEARCH;
            r_match  <= 4'd0;
            r_htotal <= '0;
            r_vtotal <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_match  <= w_match_nxt;
            r_htotal <= w_htotal_nxt;
            r_vtotal <= w_vtotal_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_match_nxt  = r_match;
        w_htotal_nxt = r_htotal;
        w_vtotal_nxt = r_vtotal;
        case (r_state)
            SEARCH: begin
                if (w_vs_start) begin
                    w_htotal_nxt = w_hcur;
                    w_vtotal_nxt = w_vcur;
                    w_match_nxt  = 4'd0;
                    w_state_nxt  = CHECK;
                end
            end
            CHECK: begin
                if (w_vs_start) begin
                    if ((w_hcur == r_htotal) && (w_vcur == r_vtotal)) begin
                        w_match_nxt = w_match_inc[3:0];
                        if (w_match_inc >= c_LOCK) begin
                            w_state_nxt = LOCKED;
                        end
                    end else begin
                        w_htotal_nxt = w_hcur;
                        w_vtotal_nxt = w_vcur;
                        w_match_nxt  = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if ((w_hs_start && (w_xlen != r_htotal)) ||
                    (w_vs_start && (r_ycnt != r_vtotal))) begin
                    w_state_nxt = SEARCH;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
        if (w_hto) begin
            w_state_nxt = SEARCH;
        end
    end

    assign pixTick    = w_pix;
    assign xPos       = r_xcnt;
    assign yPos       = r_ycnt;
    assign hTotal     = r_htotal;
    assign vTotal     = r_vtotal;
    assign frameStart = w_vs_start;
    assign locked     = (r_state == LOCKED);

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing path: takes an incoming hsync/vsync pair on the system clock, re-derives the divide-by-4 pixel enable phase-aligned to each hsync leading edge, and tracks pixel/line position. It measures line length (in pixel ticks) and frame length (in lines), and asserts `locked` once the timing is stable over consecutive frames. It sits between an external VGA source and downstream capture/overlay logic that needs a pixel strobe and coordinates.

## Interface
- `CNT_W`, 11, width of all position/measurement counters
- `LOCK_FRAMES`, 2, consecutive matching frames required to lock (1..15)
- `SYNC_POL`, 0, active level of hsync/vsync (0 = active-low)

- `clock` in 1 — system clock (4× pixel rate)
- `reset` in 1 — asynchronous, active-low; clears all state
- `hsync` in 1 — incoming horizontal sync
- `vsync` in 1 — incoming vertical sync
- `pixTick` out 1 — one-cycle pixel enable, every 4th clock
- `xPos` out CNT_W — pixel ticks since last line start
- `yPos` out CNT_W — lines since last frame start
- `hTotal` out CNT_W — locked line length in pixel ticks
- `vTotal` out CNT_W — locked frame length in lines
- `frameStart` out 1 — one-cycle pulse on every vsync leading edge
- `locked` out 1 — timing stable

## Operation
- Sampling: sync inputs registered once (`hs_q`, `vs_q`), XORed with `SYNC_POL` inversion; previous sample kept. `hsStart` = active now & inactive previous; `vsStart` likewise.
- Phase: 2-bit `phase`; on `hsStart` → 0, else +1 (wraps 3→0). `pixTick = (phase == 3)`.
- `xCnt`: on `hsStart` → `hMeas <= xCnt`, `xCnt <= 0`; else +1 on `pixTick`; saturates at all-ones (sets `hTimeout`).
- `yCnt`: +1 on `hsStart`; on `vsStart` → `vMeas <= yCnt`, `yCnt <= 0`. Simultaneous `hsStart` & `vsStart`: `yCnt <= 0`, `vMeas` takes pre-increment value.
- Lock FSM, states SEARCH, CHECK, LOCKED; evaluated on `vsStart` using `hMeas` and `vMeas`:
  - SEARCH: store `hTotal <= hMeas`, `vTotal <= vMeas`, `match <= 0` → CHECK.
  - CHECK: if both equal stored: `match+1`; reaching `LOCK_FRAMES` → LOCKED. Else reload stored, `match <= 0`, stay CHECK.
  - LOCKED: any `hsStart` whose `xCnt` ≠ `hTotal`, any `vsStart` whose `yCnt` ≠ `vTotal`, or `hTimeout` → SEARCH.
  - `hTimeout` in any state → SEARCH.
- `locked = (state == LOCKED)`; `hTotal`/`vTotal` hold last stored values, meaningful only while locked.
- `xPos = xCnt`, `yPos = yCnt`, `frameStart = vsStart`.

## Timing
- Reset (async assert, sync-released effect on next edge): `phase=0`, all counters/measurements 0, state SEARCH, sync samples inactive; outputs `pixTick=0, xPos=0, yPos=0, hTotal=0, vTotal=0, frameStart=0, locked=0`.
- Input edge → `hsStart`/`vsStart`/`frameStart` high in cycle after the clock edge sampling it (latency 1, plus macro latency below).
- `hsStart` cycle: next edge sets `phase=0`, so first `pixTick` of the line is 4 clocks after `hsStart`.
- `locked` rises the cycle after the `vsStart` completing the LOCK_FRAMES-th match; falls the cycle after the offending event.
- Reset mid-frame: state discarded; minimum 1+LOCK_FRAMES full frames to relock.
- Glitch shorter than one clock may be missed; no filtering.

## Configuration
- `VGA_SYNC_DECODER_SYNC_EN`: defined → two-flop synchronizer ahead of the sampling register on `hsync`/`vsync`; all input-to-event latencies +2 cycles. Undefined → inputs assumed synchronous to `clock`, single sampling register only.

## Test plan
- Reset low mid-run → all outputs 0 immediately, `locked=0`, state SEARCH.
- Active-low source, 100 ticks/line (400 clocks), 10 lines/frame, 3 frames → `pixTick` every 4 clocks aligned to hsync, `locked=1` after 3rd `vsStart`, `hTotal=100`, `vTotal=10`.
- While locked, one line shortened to 99 ticks → `locked=0` the cycle after that `hsStart`; relocks after 3 further clean frames.
- hsync stopped → `xCnt` saturates at 2047, `locked=0`, state SEARCH.
- hsync and vsync leading edges same cycle → `yPos=0`, `vMeas` = prior line count, `frameStart=1` single cycle.
- With `VGA_SYNC_DECODER_SYNC_EN` defined → `frameStart` 3 cycles after vsync edge (vs 1 without).
